// File: rtl/note_judge_if.sv
// Lane control and status bundle between the gameplay driver and the note judge.
// The master side drives the lane inputs; the slave side (the judge) returns erase and scoring.
interface note_judge_if #(
  parameter int LANES = 8
);
  logic             i_run;
  logic             i_clear;
  logic             i_level;
  logic             i_step;
  logic [LANES-1:0] i_v_enb;
  logic [LANES-1:0] i_key;
  logic [LANES-1:0] o_erase;
  logic             o_hit;
  logic [15:0]      o_score;
  logic [7:0]       o_miss;
  logic             o_game_over;

  modport master (
    output i_run, i_clear, i_level, i_step, i_v_enb, i_key,
    input  o_erase, o_hit, o_score, o_miss, o_game_over
  );

  modport slave (
    input  i_run, i_clear, i_level, i_step, i_v_enb, i_key,
    output o_erase, o_hit, o_score, o_miss, o_game_over
  );
endinterface

// File: rtl/note_judge.sv
// Gameplay judge: mirrors each lane's falling block position, classifies key presses,
// drives erase back to the display and keeps score, miss count and game-over state.
module note_judge #(
  parameter int         LANES    = 8,
  parameter int         LIMIT    = 640,
  parameter int         HIT_LO   = 400,
  parameter int         HIT_HI   = 560,
  parameter logic [7:0] MAX_MISS = 8'd10
) (
  input  logic       clk,
  input  logic       rst,
  note_judge_if.slave bus
);

  localparam logic [9:0] L_LIMIT  = 10'(LIMIT);
  localparam logic [9:0] L_HIT_LO = 10'(HIT_LO);
  localparam logic [9:0] L_HIT_HI = 10'(HIT_HI);

  logic [LANES-1:0] r_active;
  logic [9:0]       r_pos [LANES];
  logic [LANES-1:0] r_v_enb_d;
  logic [LANES-1:0] r_key_d;
  logic [LANES-1:0] r_erase;
  logic             r_hit;
  logic [15:0]      r_score;
  logic [7:0]       r_miss;
  logic             r_game_over;

  logic [LANES-1:0] w_spawn;
  logic [LANES-1:0] w_press;
  logic [LANES-1:0] w_hit_vec;
  logic [LANES-1:0] w_expire;
  logic [LANES-1:0] w_fall;
  logic [7:0]       w_n_hit;
  logic [7:0]       w_n_exp;
  logic [8:0]       w_pts;
  logic [16:0]      w_score_sum;
  logic [15:0]      w_score_next;
  logic [8:0]       w_miss_sum;
  logic [7:0]       w_miss_next;

  // Per-lane event resolution; priority is spawn > hit > expiry > step.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_spawn   = bus.i_v_enb & ~r_v_enb_d & {LANES{~r_game_over}};
    w_press   = bus.i_key & ~r_key_d;
    w_hit_vec = '0;
    w_expire  = '0;
    w_fall    = '0;
    w_n_hit   = '0;
    w_n_exp   = '0;
    for (int i = 0; i < LANES; i++) begin
      w_hit_vec[i] = !w_spawn[i] && w_press[i] && r_active[i] && !r_erase[i] &&
                     (r_pos[i] >= L_HIT_LO) && (r_pos[i] <= L_HIT_HI);
      w_expire[i]  = !w_spawn[i] && !w_hit_vec[i] && r_active[i] && !r_erase[i] &&
                     (r_pos[i] == L_LIMIT);
      w_fall[i]    = !w_spawn[i] && !w_hit_vec[i] && !w_expire[i] && r_active[i] &&
                     bus.i_step;
      w_n_hit      = w_n_hit + 8'(w_hit_vec[i]);
      w_n_exp      = w_n_exp + 8'(w_expire[i]);
    end
    w_pts        = bus.i_level ? {w_n_hit, 1'b0} : {1'b0, w_n_hit};
    w_score_sum  = {1'b0, r_score} + {8'b0, w_pts};
    w_score_next = w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
    w_miss_sum   = {1'b0, r_miss} + {1'b0, w_n_exp};
    w_miss_next  = w_miss_sum[8] ? 8'hFF : w_miss_sum[7:0];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  // NOTE: the position array is reset explicitly; it is a register bank, not a RAM, and stale positions would fake hits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_active    <= '0;
      r_v_enb_d   <= '0;
      r_key_d     <= '0;
      r_erase     <= '0;
      r_hit       <= 1'b0;
      r_score     <= '0;
      r_miss      <= '0;
      r_game_over <= 1'b0;
      for (int i = 0; i < LANES; i++) r_pos[i] <= '0;
    end else if (bus.i_clear) begin
      r_active    <= '0;
      r_v_enb_d   <= '0;
      r_key_d     <= '0;
      r_erase     <= '0;
      r_hit       <= 1'b0;
      r_score     <= '0;
      r_miss      <= '0;
      r_game_over <= 1'b0;
      for (int i = 0; i < LANES; i++) r_pos[i] <= '0;
    end else begin
      // Edge trackers follow the inputs even while paused so resuming fires no stale edge.
      r_v_enb_d <= bus.i_v_enb;
      r_key_d   <= bus.i_key;
      r_hit     <= 1'b0;
      if (bus.i_run) begin
        r_hit       <= |w_hit_vec;
        r_score     <= w_score_next;
        r_miss      <= w_miss_next;
        r_game_over <= r_game_over | (w_miss_next >= MAX_MISS);
        for (int i = 0; i < LANES; i++) begin
          if (w_spawn[i]) begin
            r_pos[i]    <= '0;
            r_active[i] <= 1'b1;
            r_erase[i]  <= 1'b0;
          end else if (w_hit_vec[i]) begin
            r_erase[i]  <= 1'b1;
            r_active[i] <= 1'b0;
          end else if (w_expire[i]) begin
            r_active[i] <= 1'b0;
          end else if (w_fall[i]) begin
            r_pos[i]    <= r_pos[i] + 10'd1;
          end
        end
      end
    end
  end

  assign bus.o_erase     = r_erase;
  assign bus.o_hit       = r_hit;
  assign bus.o_score     = r_score;
  assign bus.o_miss      = r_miss;
  assign bus.o_game_over = r_game_over;

endmodule
